mem_port_arbiter: RTL

- Shares the single-port program/data block RAM between two requesters: the multicycle CPU controller/datapath (port 0: fetch, LOAD, STORE) and the game I/O scanner (port 1: puzzle-module state, display buffer).
- Sequences each access as a fixed three-state transaction with a one-cycle RAM read latency.
- Returns a one-cycle ack per transaction.
- Arbitration is round-robin or CPU fixed priority, selected by parameter.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter_pick2.sv | 25 ++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the RAM port arbiter: FSM state encoding and port ids.
// Imported by the arbiter top and its winner-select sub-module.
package mem_arb_pkg;

   // 2'b11 is unused and falls back to IDLE in the FSM default branch.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      RESP  = 2'b10
   } arb_state_e;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_IO  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of both requester ports and the RAM side of the arbiter.
// slave: arbiter view; master: requesters/RAM (testbench) view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              req0;
   logic              we0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              ack0;
   logic [DATA_W-1:0] rdata0;

   logic              req1;
   logic              we1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              ack1;
   logic [DATA_W-1:0] rdata1;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  mem_rdata,
      output ack0, rdata0, ack1, rdata1,
      output mem_addr, mem_wdata, mem_we, busy
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output mem_rdata,
      input  ack0, rdata0, ack1, rdata1,
      input  mem_addr, mem_wdata, mem_we, busy
   );

endinterface

// File: rtl/mem_port_arbiter_pick2.sv
// Two-way winner select: req0_i/req1_i/last_srv_i in; valid_o, gnt_o out.
// Ties go to the port not served last, or always to port 0 in priority mode.
module arb_pick2
   import mem_arb_pkg::*;
#(
   parameter int CPU_PRIORITY = 0
) (
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_srv_i,
   output logic valid_o,
   output logic gnt_o
);

   always_comb begin
      valid_o = req0_i | req1_i;
      gnt_o   = PORT_CPU;
      if (req0_i && req1_i) begin
         gnt_o = (CPU_PRIORITY != 0) ? PORT_CPU : ~last_srv_i;
      end else if (req1_i) begin
         gnt_o = PORT_IO;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between CPU (port 0) and I/O scanner (port 1).
// Ports: clock, reset (sync, active-high), bus (slave view of the interface).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int CPU_PRIORITY = 0
) (
   input  logic               clock,
   input  logic               reset,
   mem_port_arbiter_if.slave  bus
);

   arb_state_e        state_q;
   logic              gnt_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              mem_we_q;
   logic              ack_q;
   logic              busy_q;
   logic              last_srv_q;
   logic [DATA_W-1:0] hold0_q;
   logic [DATA_W-1:0] hold1_q;

   logic              pick_valid;
   logic              pick_gnt;
   logic              win_we_d;
   logic [ADDR_W-1:0] win_addr_d;
   logic [DATA_W-1:0] win_wdata_d;
   logic              rd_live;

   arb_pick2 #(
      .CPU_PRIORITY (CPU_PRIORITY)
   ) u_pick (
      .req0_i     (bus.req0),
      .req1_i     (bus.req1),
      .last_srv_i (last_srv_q),
      .valid_o    (pick_valid),
      .gnt_o      (pick_gnt)
   );

   assign win_we_d    = pick_gnt ? bus.we1    : bus.we0;
   assign win_addr_d  = pick_gnt ? bus.addr1  : bus.addr0;
   assign win_wdata_d = pick_gnt ? bus.wdata1 : bus.wdata0;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         gnt_q      <= PORT_CPU;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         mem_we_q   <= 1'b0;
         ack_q      <= 1'b0;
         busy_q     <= 1'b0;
         last_srv_q <= PORT_IO;
         hold0_q    <= '0;
         hold1_q    <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  gnt_q      <= pick_gnt;
                  we_q       <= win_we_d;
                  addr_q     <= win_addr_d;
                  wdata_q    <= win_wdata_d;
                  mem_we_q   <= win_we_d;
                  last_srv_q <= pick_gnt;
                  busy_q     <= 1'b1;
                  state_q    <= ISSUE;
               end
            end
            ISSUE: begin
               mem_we_q <= 1'b0;
               ack_q    <= 1'b1;
               state_q  <= RESP;
            end
            RESP: begin
               ack_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
               if (!we_q) begin
                  if (gnt_q == PORT_CPU) hold0_q <= bus.mem_rdata;
                  else                   hold1_q <= bus.mem_rdata;
               end
            end
            default: begin
               mem_we_q <= 1'b0;
               ack_q    <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   // RAM data is only live during RESP of a read; otherwise show the hold.
   assign rd_live = (state_q == RESP) && !we_q;

   assign bus.rdata0 = (rd_live && gnt_q == PORT_CPU) ? bus.mem_rdata : hold0_q;
   assign bus.rdata1 = (rd_live && gnt_q == PORT_IO)  ? bus.mem_rdata : hold1_q;

   assign bus.ack0      = ack_q && (gnt_q == PORT_CPU);
   assign bus.ack1      = ack_q && (gnt_q == PORT_IO);
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.busy      = busy_q;

endmodule
